// File: rtl/data_cache_if.sv
// data_cache_if
//   Bundles the CPU load/store port and the 128-bit block memory port of the
//   data cache into one interface.
//   Modports:
//     slave  - the cache: takes CPU requests and drives the memory request
//              signals (read, write, address, writedata, mem_readdata and
//              mem_busywait in; readdata, busywait and mem_* requests out).
//     master - the environment (CPU + block memory), the mirror image.
interface data_cache_if;
    // CPU side
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;
    // Block memory side
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/data_cache.sv
// data_cache
//   Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
//   Hits complete with no wait cycles; a miss writes back a dirty victim line,
//   fetches the missing block and then resolves as a hit.
//   Ports:
//     clock - system clock, rising edge
//     reset - asynchronous, active-high; invalidates every line
//     bus   - data_cache_if.slave: CPU request/response and block memory port
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    data_cache_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t state_q, state_d;

    logic             valid_q [LINES];
    logic             valid_d [LINES];
    logic             dirty_q [LINES];
    logic             dirty_d [LINES];
    logic [TAG_W-1:0] tag_q   [LINES];
    logic [TAG_W-1:0] tag_d   [LINES];
    logic [127:0]     data_q  [LINES];
    logic [127:0]     data_d  [LINES];

    logic [127:0] fill_q, fill_d;
    logic         seen_busy_q, seen_busy_d;
    logic [27:0]  mem_address_q, mem_address_d;
    logic [127:0] mem_writedata_q, mem_writedata_d;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      addr_tag;
    logic                  access;
    logic                  hit;
    logic                  xfer;
    logic                  done;
    logic                  unused_addr_bits;

    function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] off);
        case (off)
            2'd0:    word_of = line[31:0];
            2'd1:    word_of = line[63:32];
            2'd2:    word_of = line[95:64];
            default: word_of = line[127:96];
        endcase
    endfunction

    function automatic logic [127:0] word_merge(input logic [127:0] line, input logic [1:0] off,
                                                input logic [31:0] word);
        word_merge = line;
        case (off)
            2'd0:    word_merge[31:0]   = word;
            2'd1:    word_merge[63:32]  = word;
            2'd2:    word_merge[95:64]  = word;
            default: word_merge[127:96] = word;
        endcase
    endfunction

    assign offset           = bus.address[3:2];
    assign index            = bus.address[3+INDEX_BITS:4];
    assign addr_tag         = bus.address[31:4+INDEX_BITS];
    assign unused_addr_bits = ^bus.address[1:0];

    // read and write together is deliberately treated as no request at all.
    assign access = bus.read ^ bus.write;
    assign hit    = access && valid_q[index] && (tag_q[index] == addr_tag);
    assign xfer   = (state_q == WRITEBACK) || (state_q == FETCH);
    // A transfer only counts as finished once the memory has been seen busy,
    // so a memory that is slow to raise busywait cannot fake completion.
    assign done   = seen_busy_q && !bus.mem_busywait;

    assign bus.readdata = word_of(data_q[index], offset);

    // State register (control state is reset, line contents are not).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            seen_busy_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            state_q         <= state_d;
            seen_busy_q     <= seen_busy_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
        end
    end

    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
        fill_q <= fill_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (access && !hit) state_d = dirty_q[index] ? WRITEBACK : FETCH;
            WRITEBACK: if (done) state_d = FETCH;
            FETCH:     if (done) state_d = UPDATE;
            UPDATE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic: requests drop combinationally on done so the memory
    // never sees a second request for the same transfer.
    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = mem_address_q;
        bus.mem_writedata = mem_writedata_q;
        case (state_q)
            WRITEBACK: begin
                bus.mem_write     = !done;
                bus.mem_address   = {tag_q[index], index};
                bus.mem_writedata = data_q[index];
            end
            FETCH: begin
                bus.mem_read    = !done;
                bus.mem_address = {addr_tag, index};
            end
            default: ;
        endcase
        bus.busywait = access && (!hit || (state_q != IDLE));
    end

    // Line storage, fill buffer and memory-port holding registers.
    always_comb begin
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        tag_d           = tag_q;
        data_d          = data_q;
        fill_d          = fill_q;
        seen_busy_d     = seen_busy_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;

        if (state_d != state_q) begin
            seen_busy_d = 1'b0;
        end else if (xfer && bus.mem_busywait) begin
            seen_busy_d = 1'b1;
        end

        // Remember what was last put on the memory port so it holds afterwards.
        if (xfer) begin
            mem_address_d   = bus.mem_address;
            mem_writedata_d = bus.mem_writedata;
        end

        if ((state_q == FETCH) && done) begin
            fill_d = bus.mem_readdata;
        end

        if (state_q == UPDATE) begin
            data_d[index]  = fill_q;
            tag_d[index]   = addr_tag;
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
        end

        // Store hit (including the store that caused an allocate, which
        // becomes a hit once the line is filled).
        if ((state_q == IDLE) && hit && bus.write) begin
            data_d[index]  = word_merge(data_q[index], offset, bus.writedata);
            dirty_d[index] = 1'b1;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
//   Self-checking bench for data_cache. A block memory responder with random
//   latency serves the memory port; a reference model (the word-level view of
//   memory the CPU should see, plus which block each index holds and whether
//   it was modified) predicts read data, hits and memory traffic.
module tb_data_cache;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    data_cache_if bus();

    data_cache #(.INDEX_BITS(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- block memory responder ----------------
    logic [127:0] blk [256];
    logic         mem_loaded = 1'b0;
    int unsigned  m_phase;
    int unsigned  m_cnt;
    logic         m_is_wr;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata;
    int           n_rd = 0;
    int           n_wr = 0;
    logic [27:0]  last_rd_addr;
    logic [27:0]  last_wr_addr;
    logic [127:0] last_wr_data;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase          <= 0;
            bus.mem_busywait <= 1'b0;
            if (!mem_loaded) begin
                for (int b = 0; b < 256; b++)
                    blk[b] <= {$urandom(), $urandom(), $urandom(), $urandom()};
                mem_loaded       <= 1'b1;
                bus.mem_readdata <= '0;
            end
        end else begin
            case (m_phase)
                0: if (bus.mem_read || bus.mem_write) begin
                    m_is_wr <= bus.mem_write;
                    m_addr  <= bus.mem_address;
                    m_wdata <= bus.mem_writedata;
                    m_cnt   <= $urandom_range(0, 2);
                    m_phase <= 1;
                    if (bus.mem_write) n_wr <= n_wr + 1;
                    else               n_rd <= n_rd + 1;
                end
                1: if (m_cnt == 0) begin
                    bus.mem_busywait <= 1'b1;
                    m_cnt            <= $urandom_range(1, 4);
                    m_phase          <= 2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: if (m_cnt <= 1) begin
                    bus.mem_busywait <= 1'b0;
                    m_phase          <= 0;
                    if (m_is_wr) begin
                        blk[m_addr[7:0]] <= m_wdata;
                        last_wr_addr     <= m_addr;
                        last_wr_data     <= m_wdata;
                    end else begin
                        bus.mem_readdata <= blk[m_addr[7:0]];
                        last_rd_addr     <= m_addr;
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            endcase
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mdl_word [1024];
    logic        mv [8];
    logic        md [8];
    logic [24:0] mt [8];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // After a reset the cache holds nothing, so memory is the whole truth.
    task automatic model_from_memory();
        for (int b = 0; b < 256; b++)
            for (int k = 0; k < 4; k++)
                mdl_word[b*4+k] = blk[b][k*32 +: 32];
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
    endtask

    function automatic logic [127:0] model_block(input logic [7:0] b);
        logic [127:0] r;
        for (int k = 0; k < 4; k++)
            r[k*32 +: 32] = mdl_word[{b, 2'(k)}];
        return r;
    endfunction

    task automatic cpu_op(input logic is_wr, input logic [31:0] addr, input logic [31:0] wd);
        logic [2:0]  idx;
        logic [24:0] tg;
        logic [27:0] victim;
        logic        hit;
        logic        dirty;
        int          rd0;
        int          wr0;
        int          cyc;
        idx    = addr[6:4];
        tg     = addr[31:7];
        hit    = mv[idx] && (mt[idx] == tg);
        dirty  = mv[idx] && md[idx];
        victim = {mt[idx], idx};
        rd0    = n_rd;
        wr0    = n_wr;
        @(negedge clock);
        bus.read      = !is_wr;
        bus.write     = is_wr;
        bus.address   = addr;
        bus.writedata = wd;
        #1;
        check("busywait_on_request", 128'(bus.busywait), 128'(!hit));
        if (!hit) begin
            @(negedge clock);
            #1;
            if (dirty) begin
                check("wb_request", 128'(bus.mem_write), 128'(1'b1));
                check("wb_address", 128'(bus.mem_address), 128'(victim));
            end else begin
                check("fill_request", 128'(bus.mem_read), 128'(1'b1));
                check("fill_address", 128'(bus.mem_address), 128'(addr[31:4]));
            end
        end
        cyc = 0;
        while (bus.busywait && cyc < 200) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check("busywait_released", 128'(bus.busywait), 128'(1'b0));
        if (!is_wr)
            check("readdata", 128'(bus.readdata), 128'(mdl_word[addr[11:2]]));
        check("mem_read_transfers", 128'(n_rd - rd0), 128'(hit ? 0 : 1));
        check("mem_write_transfers", 128'(n_wr - wr0), 128'((!hit && dirty) ? 1 : 0));
        if (!hit) check("fill_address_seen", 128'(last_rd_addr), 128'(addr[31:4]));
        if (!hit && dirty) check("writeback_line", blk[victim[7:0]], model_block(victim[7:0]));
        if (is_wr) mdl_word[addr[11:2]] = wd;
        if (!hit) begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = 1'b0;
        end
        if (is_wr) md[idx] = 1'b1;
        @(negedge clock);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int wr0;
        int cyc;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        repeat (3) @(negedge clock);
        check("reset_busywait", 128'(bus.busywait), 128'(1'b0));
        check("reset_mem_read", 128'(bus.mem_read), 128'(1'b0));
        check("reset_mem_write", 128'(bus.mem_write), 128'(1'b0));
        check("reset_mem_address", 128'(bus.mem_address), 128'(0));
        check("reset_mem_writedata", bus.mem_writedata, 128'(0));
        reset = 1'b0;
        @(negedge clock);
        model_from_memory();

        // Directed sequence
        cpu_op(1'b0, 32'h0000_0000, 32'h0);
        cpu_op(1'b0, 32'h0000_0004, 32'h0);
        cpu_op(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        cpu_op(1'b0, 32'h0000_0008, 32'h0);
        check("store_word_readback", 128'(mdl_word[2]), 128'(32'hDEAD_BEEF));
        cpu_op(1'b0, 32'h0000_0080, 32'h0);
        check("victim_address", 128'(last_wr_addr), 128'(28'h0));
        check("victim_word2", 128'(last_wr_data[95:64]), 128'(32'hDEAD_BEEF));
        check("refill_address", 128'(last_rd_addr), 128'(28'h8));

        // Reset in the middle of a block fetch
        @(negedge clock);
        bus.read    = 1'b1;
        bus.address = 32'h0000_0100;
        cyc = 0;
        while (!bus.mem_read && cyc < 20) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check("fetch_started", 128'(bus.mem_read), 128'(1'b1));
        reset    = 1'b1;
        bus.read = 1'b0;
        #1;
        check("reset_drops_mem_read", 128'(bus.mem_read), 128'(1'b0));
        check("reset_drops_busywait", 128'(bus.busywait), 128'(1'b0));
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        model_from_memory();
        cpu_op(1'b0, 32'h0000_0000, 32'h0);

        // read and write together: no access
        rd0 = n_rd;
        wr0 = n_wr;
        @(negedge clock);
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        bus.address   = 32'h0000_0008;
        bus.writedata = 32'h1234_5678;
        #1;
        check("both_busywait", 128'(bus.busywait), 128'(1'b0));
        check("both_mem_read", 128'(bus.mem_read), 128'(1'b0));
        repeat (4) @(negedge clock);
        check("both_mem_write", 128'(bus.mem_write), 128'(1'b0));
        check("both_no_transfers", 128'((n_rd - rd0) + (n_wr - wr0)), 128'(0));
        bus.read  = 1'b0;
        bus.write = 1'b0;
        cpu_op(1'b0, 32'h0000_0008, 32'h0);

        // Randomized traffic over a few tags per index
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic        w;
            a = {23'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'b00};
            w = 1'($urandom_range(0, 1));
            cpu_op(w, a, $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
